control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_pkg.sv | 38 +++
 rtl/cu_decoder.sv | 46 ++++
 rtl/control_unit.sv | 121 ++++++++++++
 tb/tb_control_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the accumulator-machine control unit: opcodes,
// ALU operation encodings and the sequencer state type.
package cu_pkg;

    localparam int CU_OPCODE_W = 4;
    localparam int ALU_CODE_W  = 3;

    localparam logic [CU_OPCODE_W-1:0] OP_NOP = 4'h0;
    localparam logic [CU_OPCODE_W-1:0] OP_LDA = 4'h1;
    localparam logic [CU_OPCODE_W-1:0] OP_STA = 4'h2;
    localparam logic [CU_OPCODE_W-1:0] OP_ADD = 4'h3;
    localparam logic [CU_OPCODE_W-1:0] OP_SUB = 4'h4;
    localparam logic [CU_OPCODE_W-1:0] OP_AND = 4'h5;
    localparam logic [CU_OPCODE_W-1:0] OP_OR  = 4'h6;
    localparam logic [CU_OPCODE_W-1:0] OP_XOR = 4'h7;
    localparam logic [CU_OPCODE_W-1:0] OP_LDI = 4'h8;
    localparam logic [CU_OPCODE_W-1:0] OP_JMP = 4'h9;
    localparam logic [CU_OPCODE_W-1:0] OP_JZ  = 4'hA;
    localparam logic [CU_OPCODE_W-1:0] OP_JNZ = 4'hB;
    localparam logic [CU_OPCODE_W-1:0] OP_HLT = 4'hF;

    localparam logic [ALU_CODE_W-1:0] ALU_PASS_B = 3'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD    = 3'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB    = 3'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_AND    = 3'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_OR     = 3'd4;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR    = 3'd5;

    typedef enum logic [2:0] {
        ST_BOOT     = 3'd0,
        ST_FETCH_HI = 3'd1,
        ST_FETCH_LO = 3'd2,
        ST_DECODE   = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_HALT     = 3'd5
    } cu_state_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode classifier: memory read/write, immediate load,
// jump variants, halt, plus the ALU operation used when read data returns.
module cu_decoder
    import cu_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    is_read,
    output logic                    is_write,
    output logic                    is_ldi,
    output logic                    is_jmp,
    output logic                    is_jz,
    output logic                    is_jnz,
    output logic                    is_halt,
    output logic [ALU_CODE_W-1:0]   alu_code
);

    // Opcode classification; anything unlisted behaves as NOP.
    always_comb begin
        is_read  = 1'b0;
        is_write = 1'b0;
        is_ldi   = 1'b0;
        is_jmp   = 1'b0;
        is_jz    = 1'b0;
        is_jnz   = 1'b0;
        is_halt  = 1'b0;
        alu_code = ALU_PASS_B;
        case (opcode)
            OPCODE_WIDTH'(OP_LDA): is_read = 1'b1;
            OPCODE_WIDTH'(OP_STA): is_write = 1'b1;
            OPCODE_WIDTH'(OP_ADD): begin is_read = 1'b1; alu_code = ALU_ADD; end
            OPCODE_WIDTH'(OP_SUB): begin is_read = 1'b1; alu_code = ALU_SUB; end
            OPCODE_WIDTH'(OP_AND): begin is_read = 1'b1; alu_code = ALU_AND; end
            OPCODE_WIDTH'(OP_OR):  begin is_read = 1'b1; alu_code = ALU_OR;  end
            OPCODE_WIDTH'(OP_XOR): begin is_read = 1'b1; alu_code = ALU_XOR; end
            OPCODE_WIDTH'(OP_LDI): is_ldi = 1'b1;
            OPCODE_WIDTH'(OP_JMP): is_jmp = 1'b1;
            OPCODE_WIDTH'(OP_JZ):  is_jz = 1'b1;
            OPCODE_WIDTH'(OP_JNZ): is_jnz = 1'b1;
            OPCODE_WIDTH'(OP_HLT): is_halt = 1'b1;
            default: alu_code = ALU_PASS_B;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the accumulator CPU: two-byte fetch, decode,
// optional RAM wait, and a sticky halt left only through reset.
module control_unit
    import cu_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4,
    parameter int ALU_OP_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    z_flag,
    input  logic                    ram_ready,
    output logic                    pc_inc,
    output logic                    pc_write_enable,
    output logic                    ir_high_write_enable,
    output logic                    ir_low_write_enable,
    output logic                    acc_write_enable,
    output logic                    z_flag_write_enable,
    output logic                    ram_read_enable,
    output logic                    ram_write_enable,
    output logic                    halted,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    alu_b_sel
);

    cu_state_t             state_r;
    cu_state_t             next_state_s;
    logic                  is_read_s;
    logic                  is_write_s;
    logic                  is_ldi_s;
    logic                  is_jmp_s;
    logic                  is_jz_s;
    logic                  is_jnz_s;
    logic                  is_halt_s;
    logic [ALU_CODE_W-1:0] alu_code_s;

    cu_decoder #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_decoder (
        .opcode   (opcode),
        .is_read  (is_read_s),
        .is_write (is_write_s),
        .is_ldi   (is_ldi_s),
        .is_jmp   (is_jmp_s),
        .is_jz    (is_jz_s),
        .is_jnz   (is_jnz_s),
        .is_halt  (is_halt_s),
        .alu_code (alu_code_s)
    );

    // State register; reset returns to BOOT without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and strobe decode; outputs follow the state combinationally
    // so a reset immediately clears them.
    always_comb begin
        next_state_s         = state_r;
        pc_inc               = 1'b0;
        pc_write_enable      = 1'b0;
        ir_high_write_enable = 1'b0;
        ir_low_write_enable  = 1'b0;
        acc_write_enable     = 1'b0;
        z_flag_write_enable  = 1'b0;
        ram_read_enable      = 1'b0;
        ram_write_enable     = 1'b0;
        halted               = 1'b0;
        alu_op               = ALU_OP_WIDTH'(ALU_PASS_B);
        alu_b_sel            = 1'b0;
        case (state_r)
            ST_BOOT: next_state_s = ST_FETCH_HI;
            ST_FETCH_HI: begin
                ir_high_write_enable = 1'b1;
                pc_inc               = 1'b1;
                next_state_s         = ST_FETCH_LO;
            end
            ST_FETCH_LO: begin
                ir_low_write_enable = 1'b1;
                pc_inc              = 1'b1;
                next_state_s        = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_halt_s) begin
                    next_state_s = ST_HALT;
                end else if (is_read_s || is_write_s) begin
                    ram_read_enable  = is_read_s;
                    ram_write_enable = is_write_s;
                    next_state_s     = ST_MEM_WAIT;
                end else if (is_ldi_s) begin
                    acc_write_enable    = 1'b1;
                    z_flag_write_enable = 1'b1;
                    alu_b_sel           = 1'b1;
                    next_state_s        = ST_FETCH_HI;
                end else begin
                    pc_write_enable = is_jmp_s || (is_jz_s && z_flag) || (is_jnz_s && !z_flag);
                    next_state_s    = ST_FETCH_HI;
                end
            end
            ST_MEM_WAIT: begin
                // The IR opcode is stable here, so re-decoding keeps the enable unchanged.
                ram_read_enable  = is_read_s;
                ram_write_enable = is_write_s;
                if (ram_ready) begin
                    acc_write_enable    = is_read_s;
                    z_flag_write_enable = is_read_s;
                    alu_op              = ALU_OP_WIDTH'(alu_code_s);
                    next_state_s        = ST_FETCH_HI;
                end else begin
                    next_state_s = ST_MEM_WAIT;
                end
            end
            ST_HALT: halted = 1'b1;
            default: next_state_s = ST_BOOT;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: decode table, directed corner
// sequences and a randomized instruction stream against an instruction-level model.
module tb_control_unit;

    typedef struct packed {
        logic       pc_inc;
        logic       pc_we;
        logic       irh;
        logic       irl;
        logic       acc;
        logic       zwe;
        logic       rre;
        logic       rwe;
        logic       halted;
        logic [2:0] alu;
        logic       bsel;
    } out_t;

    typedef struct {
        logic [3:0] op;
        logic       z;
        out_t       exp_dec;
        bit         has_mem;
        out_t       exp_mem;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic       z_flag;
    logic       ram_ready;
    logic       pc_inc;
    logic       pc_write_enable;
    logic       ir_high_write_enable;
    logic       ir_low_write_enable;
    logic       acc_write_enable;
    logic       z_flag_write_enable;
    logic       ram_read_enable;
    logic       ram_write_enable;
    logic       halted;
    logic [2:0] alu_op;
    logic       alu_b_sel;

    int checks   = 0;
    int failures = 0;

    control_unit #(.OPCODE_WIDTH(4), .ALU_OP_WIDTH(3)) dut (
        .clk                  (clk),
        .reset                (reset),
        .opcode               (opcode),
        .z_flag               (z_flag),
        .ram_ready            (ram_ready),
        .pc_inc               (pc_inc),
        .pc_write_enable      (pc_write_enable),
        .ir_high_write_enable (ir_high_write_enable),
        .ir_low_write_enable  (ir_low_write_enable),
        .acc_write_enable     (acc_write_enable),
        .z_flag_write_enable  (z_flag_write_enable),
        .ram_read_enable      (ram_read_enable),
        .ram_write_enable     (ram_write_enable),
        .halted               (halted),
        .alu_op               (alu_op),
        .alu_b_sel            (alu_b_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (instruction level) ----------------
    function automatic bit is_rd(input logic [3:0] op);
        return (op == 4'h1) || (op >= 4'h3 && op <= 4'h7);
    endfunction

    function automatic out_t exp_fetch(input bit hi);
        out_t e = '0;
        e.pc_inc = 1'b1;
        if (hi) e.irh = 1'b1;
        else    e.irl = 1'b1;
        return e;
    endfunction

    function automatic out_t exp_decode(input logic [3:0] op, input logic z);
        out_t e = '0;
        if (is_rd(op)) e.rre = 1'b1;
        else if (op == 4'h2) e.rwe = 1'b1;
        else if (op == 4'h8) begin e.acc = 1'b1; e.zwe = 1'b1; e.bsel = 1'b1; end
        else if (op == 4'h9 || (op == 4'hA && z) || (op == 4'hB && !z)) e.pc_we = 1'b1;
        return e;
    endfunction

    function automatic out_t exp_mem(input logic [3:0] op, input logic rdy);
        out_t e = '0;
        e.rre = is_rd(op);
        e.rwe = (op == 4'h2);
        if (rdy && is_rd(op)) begin
            e.acc = 1'b1;
            e.zwe = 1'b1;
            e.alu = (op == 4'h1) ? 3'd0 : 3'(op - 4'h2);
        end
        return e;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input out_t exp);
        out_t act;
        act = {pc_inc, pc_write_enable, ir_high_write_enable, ir_low_write_enable,
               acc_write_enable, z_flag_write_enable, ram_read_enable, ram_write_enable,
               halted, alu_op, alu_b_sel};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic cyc(input string nm, input logic [3:0] op, input logic z,
                       input logic rdy, input out_t exp);
        @(negedge clk);
        opcode = op; z_flag = z; ram_ready = rdy;
        #1;
        check(nm, exp);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0; opcode = 4'($urandom); ram_ready = 1'($urandom);
        #1;
        check("boot_cycle", '0);
    endtask

    task automatic run_instr(input string nm, input logic [3:0] op, input logic z, input int waits);
        cyc({nm, "_fhi"}, 4'($urandom), 1'($urandom), 1'($urandom), exp_fetch(1'b1));
        cyc({nm, "_flo"}, 4'($urandom), 1'($urandom), 1'($urandom), exp_fetch(1'b0));
        cyc({nm, "_dec"}, op, z, 1'($urandom), exp_decode(op, z));
        if (is_rd(op) || op == 4'h2) begin
            for (int w = 0; w < waits; w++)
                cyc({nm, "_wait"}, op, 1'($urandom), 1'b0, exp_mem(op, 1'b0));
            cyc({nm, "_ready"}, op, 1'($urandom), 1'b1, exp_mem(op, 1'b1));
        end
    endtask

    vec_t tbl[$];

    function automatic out_t o(input bit pcw, input bit acc, input bit rre, input bit rwe,
                               input logic [2:0] alu, input bit bsel);
        out_t e = '0;
        e.pc_we = pcw; e.acc = acc; e.zwe = acc; e.rre = rre; e.rwe = rwe;
        e.alu = alu; e.bsel = bsel;
        return e;
    endfunction

    initial begin
        reset = 1'b1; opcode = 4'h0; z_flag = 1'b0; ram_ready = 1'b0;

        // Decode table: {op, z, decode outputs, has memory phase, ready-cycle outputs}
        tbl.push_back('{4'h0, 1'b0, o(0,0,0,0,3'd0,0), 1'b0, o(0,0,0,0,3'd0,0)});
        tbl.push_back('{4'hC, 1'b1, o(0,0,0,0,3'd0,0), 1'b0, o(0,0,0,0,3'd0,0)});
        tbl.push_back('{4'hD, 1'b0, o(0,0,0,0,3'd0,0), 1'b0, o(0,0,0,0,3'd0,0)});
        tbl.push_back('{4'hE, 1'b1, o(0,0,0,0,3'd0,0), 1'b0, o(0,0,0,0,3'd0,0)});
        tbl.push_back('{4'h8, 1'b0, o(0,1,0,0,3'd0,1), 1'b0, o(0,0,0,0,3'd0,0)});
        tbl.push_back('{4'h9, 1'b1, o(1,0,0,0,3'd0,0), 1'b0, o(0,0,0,0,3'd0,0)});
        tbl.push_back('{4'hA, 1'b0, o(0,0,0,0,3'd0,0), 1'b0, o(0,0,0,0,3'd0,0)});
        tbl.push_back('{4'hA, 1'b1, o(1,0,0,0,3'd0,0), 1'b0, o(0,0,0,0,3'd0,0)});
        tbl.push_back('{4'hB, 1'b0, o(1,0,0,0,3'd0,0), 1'b0, o(0,0,0,0,3'd0,0)});
        tbl.push_back('{4'hB, 1'b1, o(0,0,0,0,3'd0,0), 1'b0, o(0,0,0,0,3'd0,0)});
        tbl.push_back('{4'h1, 1'b0, o(0,0,1,0,3'd0,0), 1'b1, o(0,1,1,0,3'd0,0)});
        tbl.push_back('{4'h3, 1'b1, o(0,0,1,0,3'd0,0), 1'b1, o(0,1,1,0,3'd1,0)});
        tbl.push_back('{4'h4, 1'b0, o(0,0,1,0,3'd0,0), 1'b1, o(0,1,1,0,3'd2,0)});
        tbl.push_back('{4'h5, 1'b0, o(0,0,1,0,3'd0,0), 1'b1, o(0,1,1,0,3'd3,0)});
        tbl.push_back('{4'h6, 1'b1, o(0,0,1,0,3'd0,0), 1'b1, o(0,1,1,0,3'd4,0)});
        tbl.push_back('{4'h7, 1'b0, o(0,0,1,0,3'd0,0), 1'b1, o(0,1,1,0,3'd5,0)});
        tbl.push_back('{4'h2, 1'b1, o(0,0,0,1,3'd0,0), 1'b1, o(0,0,0,1,3'd0,0)});

        // Outputs idle while reset is held, then BOOT and NOP loop every 3 cycles.
        repeat (2) @(negedge clk);
        #1;
        check("in_reset", '0);
        release_reset();
        for (int i = 0; i < 2; i++) begin
            cyc("nop_fhi", 4'h0, 1'b0, 1'b0, o(0,0,0,0,3'd0,0) | exp_fetch(1'b1));
            cyc("nop_flo", 4'h0, 1'b0, 1'b0, exp_fetch(1'b0));
            cyc("nop_dec", 4'h0, 1'b0, 1'b1, '0);
        end

        // Table pass
        foreach (tbl[i]) begin
            cyc("tbl_fhi", tbl[i].op, tbl[i].z, 1'b0, exp_fetch(1'b1));
            cyc("tbl_flo", tbl[i].op, tbl[i].z, 1'b0, exp_fetch(1'b0));
            cyc($sformatf("tbl_dec_op%h_z%0d", tbl[i].op, tbl[i].z), tbl[i].op, tbl[i].z, 1'b0, tbl[i].exp_dec);
            if (tbl[i].has_mem)
                cyc($sformatf("tbl_rdy_op%h", tbl[i].op), tbl[i].op, tbl[i].z, 1'b1, tbl[i].exp_mem);
        end

        // ADD with three not-ready cycles, hand-checked
        cyc("add_fhi", 4'h3, 1'b0, 1'b1, exp_fetch(1'b1));
        cyc("add_flo", 4'h3, 1'b0, 1'b1, exp_fetch(1'b0));
        cyc("add_dec", 4'h3, 1'b0, 1'b0, o(0,0,1,0,3'd0,0));
        repeat (3) cyc("add_wait", 4'h3, 1'b1, 1'b0, o(0,0,1,0,3'd0,0));
        cyc("add_ready", 4'h3, 1'b0, 1'b1, o(0,1,1,0,3'd1,0));
        cyc("add_next_fhi", 4'h0, 1'b0, 1'b1, exp_fetch(1'b1));

        // STA with ram_ready already high in DECODE: still two write cycles
        cyc("sta_flo", 4'h2, 1'b0, 1'b1, exp_fetch(1'b0));
        cyc("sta_dec", 4'h2, 1'b0, 1'b1, o(0,0,0,1,3'd0,0));
        cyc("sta_mem", 4'h2, 1'b0, 1'b1, o(0,0,0,1,3'd0,0));
        cyc("sta_after", 4'h2, 1'b0, 1'b1, exp_fetch(1'b1));

        // LDA aborted by an asynchronous reset pulse inside MEM_WAIT
        cyc("lda_flo", 4'h1, 1'b0, 1'b0, exp_fetch(1'b0));
        cyc("lda_dec", 4'h1, 1'b0, 1'b0, o(0,0,1,0,3'd0,0));
        cyc("lda_wait", 4'h1, 1'b0, 1'b0, o(0,0,1,0,3'd0,0));
        #1;
        reset = 1'b1;
        ram_ready = 1'b1;
        #1;
        check("lda_async_reset", '0);
        release_reset();
        cyc("post_rst_fhi", 4'h1, 1'b0, 1'b1, exp_fetch(1'b1));

        // Randomized instruction stream (no HLT)
        cyc("rnd_flo0", 4'h0, 1'b0, 1'b0, exp_fetch(1'b0));
        cyc("rnd_dec0", 4'h0, 1'b0, 1'b0, '0);
        for (int n = 0; n < 200; n++)
            run_instr("rnd", 4'($urandom_range(0, 14)), 1'($urandom), int'($urandom_range(0, 3)));

        // HLT: halted for 20 cycles whatever the inputs, until reset
        run_instr("hlt", 4'hF, 1'b0, 0);
        for (int n = 0; n < 20; n++)
            cyc("halted", 4'($urandom), 1'($urandom), 1'($urandom), 24'h0 | 13'b0000000010000);
        #1;
        reset = 1'b1;
        #1;
        check("halt_reset", '0);
        release_reset();
        cyc("after_halt_fhi", 4'hF, 1'b0, 1'b0, exp_fetch(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
